// File: rtl/sm3_expnd_if.sv
// SM3 message-expansion buses: padding-stage word input and per-round expansion output.
// slave = expansion stage side, master = padding stage / compression core side.
interface sm3_expnd_if;
  localparam int unsigned WRD_W = 32;

  logic [WRD_W-1:0] pad_inpt_wrd_i;
  logic             pad_inpt_vld_i;
  logic             pad_inpt_lst_i;
  logic             pad_inpt_rdy_o;
  logic [WRD_W-1:0] expnd_otpt_wj_o;
  logic [WRD_W-1:0] expnd_otpt_wjj_o;
  logic             expnd_otpt_lst_o;
  logic             expnd_otpt_vld_o;

  modport slave (
    input  pad_inpt_wrd_i, pad_inpt_vld_i, pad_inpt_lst_i,
    output pad_inpt_rdy_o, expnd_otpt_wj_o, expnd_otpt_wjj_o,
           expnd_otpt_lst_o, expnd_otpt_vld_o
  );

  modport master (
    output pad_inpt_wrd_i, pad_inpt_vld_i, pad_inpt_lst_i,
    input  pad_inpt_rdy_o, expnd_otpt_wj_o, expnd_otpt_wjj_o,
           expnd_otpt_lst_o, expnd_otpt_vld_o
  );
endinterface

// File: rtl/sm3_expnd_sched.sv
// SM3 message expansion: loads 16 words, emits Wj / W'j for j=0..63, one round per cycle.
// Optional next-block prefetch shadow buffer: macro SM3_EXPND_PREFETCH_EN (from sm3_cfg.v).
module sm3_expnd_sched (
  input  logic       clk,
  input  logic       rst_n,
  sm3_expnd_if.slave bus
);
  localparam int unsigned WRD_W   = 32;
  localparam int unsigned WRD_NUM = 16;
  localparam int unsigned RND_NUM = 64;
  localparam int unsigned WCNT_W  = $clog2(WRD_NUM);
  localparam int unsigned RCNT_W  = $clog2(RND_NUM);
  localparam int unsigned SCNT_W  = WCNT_W + 1;

  typedef enum logic {LOAD = 1'b0, EXPND = 1'b1} state_e;
  typedef logic [WRD_W-1:0] word_t;

  function automatic word_t rotl(input word_t x, input int unsigned n);
    return (x << n) | (x >> (WRD_W - n));
  endfunction

  function automatic word_t p1(input word_t x);
    return x ^ rotl(x, 15) ^ rotl(x, 23);
  endfunction

  // W(j+16) from the window taps W(j), W(j+3), W(j+7), W(j+10), W(j+13)
  function automatic word_t next_w(input word_t w0, input word_t w3, input word_t w7,
                                   input word_t w10, input word_t w13);
    return p1(w0 ^ w7 ^ rotl(w13, 15)) ^ rotl(w3, 7) ^ w10;
  endfunction

  state_e            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [RCNT_W-1:0] rcnt_q, rcnt_d;
  word_t             win_q [WRD_NUM];
  word_t             win_d [WRD_NUM];
  logic              lst_q, lst_d;

  logic              rdy_q, rdy_d;
  logic              vld_q, vld_d;
  logic              lsto_q, lsto_d;
  word_t             wj_q, wj_d;
  word_t             wjj_q, wjj_d;

  logic              xfer;

`ifdef SM3_EXPND_PREFETCH_EN
  word_t             sh_q [WRD_NUM];
  word_t             sh_d [WRD_NUM];
  logic [SCNT_W-1:0] scnt_q, scnt_d;
  logic              shlst_q, shlst_d;
`endif

  assign xfer = bus.pad_inpt_vld_i & rdy_q;

  // State, window and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      wcnt_q  <= '0;
      rcnt_q  <= '0;
      lst_q   <= 1'b0;
      for (int unsigned k = 0; k < WRD_NUM; k++) win_q[k] <= '0;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
      lsto_q  <= 1'b0;
      wj_q    <= '0;
      wjj_q   <= '0;
`ifdef SM3_EXPND_PREFETCH_EN
      for (int unsigned k = 0; k < WRD_NUM; k++) sh_q[k] <= '0;
      scnt_q  <= '0;
      shlst_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      rcnt_q  <= rcnt_d;
      lst_q   <= lst_d;
      win_q   <= win_d;
      rdy_q   <= rdy_d;
      vld_q   <= vld_d;
      lsto_q  <= lsto_d;
      wj_q    <= wj_d;
      wjj_q   <= wjj_d;
`ifdef SM3_EXPND_PREFETCH_EN
      sh_q    <= sh_d;
      scnt_q  <= scnt_d;
      shlst_q <= shlst_d;
`endif
    end
  end

  // Next-state, window update and next output values
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    rcnt_d  = rcnt_q;
    lst_d   = lst_q;
    win_d   = win_q;
`ifdef SM3_EXPND_PREFETCH_EN
    sh_d    = sh_q;
    scnt_d  = scnt_q;
    shlst_d = shlst_q;
`endif

    case (state_q)
      LOAD: begin
        if (xfer) begin
          win_d[wcnt_q] = bus.pad_inpt_wrd_i;
          wcnt_d        = wcnt_q + WCNT_W'(1);
          if (wcnt_q == WCNT_W'(WRD_NUM - 1)) begin
            lst_d   = bus.pad_inpt_lst_i;
            state_d = EXPND;
            rcnt_d  = '0;
            wcnt_d  = '0;
          end
        end
      end

      EXPND: begin
        for (int unsigned k = 0; k < WRD_NUM - 1; k++) win_d[k] = win_q[k+1];
        win_d[WRD_NUM-1] = next_w(win_q[0], win_q[3], win_q[7], win_q[10], win_q[13]);
        rcnt_d = rcnt_q + RCNT_W'(1);

`ifdef SM3_EXPND_PREFETCH_EN
        if (xfer) begin
          sh_d[scnt_q[WCNT_W-1:0]] = bus.pad_inpt_wrd_i;
          scnt_d                   = scnt_q + SCNT_W'(1);
          if (scnt_q == SCNT_W'(WRD_NUM - 1)) shlst_d = bus.pad_inpt_lst_i;
        end
`endif

        if (rcnt_q == RCNT_W'(RND_NUM - 1)) begin
          state_d = LOAD;
          rcnt_d  = '0;
          wcnt_d  = '0;
`ifdef SM3_EXPND_PREFETCH_EN
          // scnt_d already includes a word accepted on this same cycle
          win_d = sh_d;
          if (scnt_d == SCNT_W'(WRD_NUM)) begin
            state_d = EXPND;
            lst_d   = shlst_d;
          end else begin
            wcnt_d  = scnt_d[WCNT_W-1:0];
          end
          scnt_d  = '0;
          shlst_d = 1'b0;
`endif
        end
      end
    endcase

`ifdef SM3_EXPND_PREFETCH_EN
    rdy_d  = (state_d == LOAD) || (scnt_d < SCNT_W'(WRD_NUM));
`else
    rdy_d  = (state_d == LOAD);
`endif
    vld_d  = (state_d == EXPND);
    wj_d   = vld_d ? win_d[0] : '0;
    wjj_d  = vld_d ? (win_d[0] ^ win_d[4]) : '0;
    lsto_d = vld_d && (rcnt_d == RCNT_W'(RND_NUM - 1)) && lst_d;
  end

  assign bus.pad_inpt_rdy_o   = rdy_q;
  assign bus.expnd_otpt_vld_o = vld_q;
  assign bus.expnd_otpt_wj_o  = wj_q;
  assign bus.expnd_otpt_wjj_o = wjj_q;
  assign bus.expnd_otpt_lst_o = lsto_q;

  a_lst_with_vld: assert property (@(posedge clk) disable iff (!rst_n)
    bus.expnd_otpt_lst_o |-> bus.expnd_otpt_vld_o);

`ifndef SM3_EXPND_PREFETCH_EN
  a_no_rdy_in_expnd: assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.expnd_otpt_vld_o && bus.pad_inpt_rdy_o));
`endif

endmodule

// File: tb/tb_sm3_expnd_sched.sv
// Directed bench for sm3_expnd_sched using the "abc" block and hand-computed expansion words.
module tb_sm3_expnd_sched;
  localparam int CAP_N = 1024;
  localparam int NVEC  = 12;

  logic clk;
  logic rst_n;
  sm3_expnd_if bus ();

  sm3_expnd_sched dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          j;
    logic [31:0] wj;
    logic [31:0] wjj;
    bit          chk_wjj;
  } vec_t;

  vec_t        tbl   [NVEC];
  logic [31:0] abc_w [16];

  int checks = 0;
  int errors = 0;

  // Output capture: every valid round is appended in order
  logic [31:0] cap_wj  [CAP_N];
  logic [31:0] cap_wjj [CAP_N];
  logic        cap_lst [CAP_N];
  int cap_n = 0, ncyc = 0, seg_n = 0, run_len = 0, last_gap = 0, last_vld_cyc = 0;
  int rdy_bad = 0, idle_bad = 0;
  bit prev_vld = 1'b0;

  always @(negedge clk) begin
    ncyc     <= ncyc + 1;
    prev_vld <= bus.expnd_otpt_vld_o;
    if (bus.expnd_otpt_vld_o) begin
      if (cap_n < CAP_N) begin
        cap_wj[cap_n]  <= bus.expnd_otpt_wj_o;
        cap_wjj[cap_n] <= bus.expnd_otpt_wjj_o;
        cap_lst[cap_n] <= bus.expnd_otpt_lst_o;
      end
      cap_n        <= cap_n + 1;
      last_vld_cyc <= ncyc;
      if (!prev_vld) begin
        seg_n   <= seg_n + 1;
        run_len <= 1;
        if (seg_n > 0) last_gap <= ncyc - last_vld_cyc - 1;
      end else begin
        run_len <= run_len + 1;
      end
      if (bus.pad_inpt_rdy_o) rdy_bad <= rdy_bad + 1;
    end else if (bus.expnd_otpt_wj_o != 0 || bus.expnd_otpt_wjj_o != 0 || bus.expnd_otpt_lst_o) begin
      idle_bad <= idle_bad + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic send_word(input logic [31:0] d, input logic l);
    bit ok = 1'b0;
    bus.pad_inpt_wrd_i = d;
    bus.pad_inpt_vld_i = 1'b1;
    bus.pad_inpt_lst_i = l;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clk);
      ok = bus.pad_inpt_rdy_o;
      @(posedge clk);
      #1;
    end
    chk("xfer_accepted", 32'(ok), 32'd1);
  endtask

  task automatic send_words(input int from, input int to, input int lst_idx, input int max_gap);
    for (int i = from; i <= to; i++) begin
      if (max_gap > 0) begin
        int g = int'($urandom_range(max_gap, 0));
        if (g > 0) begin
          bus.pad_inpt_vld_i = 1'b0;
          bus.pad_inpt_wrd_i = $urandom;
          repeat (g) begin @(posedge clk); #1; end
        end
      end
      send_word(abc_w[i], i == lst_idx);
    end
  endtask

  task automatic idle_input();
    bus.pad_inpt_vld_i = 1'b0;
    bus.pad_inpt_lst_i = 1'b0;
  endtask

  task automatic wait_rounds(input int target, input int budget);
    for (int t = 0; t < budget && cap_n < target; t++) begin
      @(negedge clk);
      #1;
    end
    chk("rounds_seen", 32'(cap_n), 32'(target));
  endtask

  task automatic check_table(input int base, input string tag);
    for (int i = 0; i < NVEC; i++) begin
      int idx = base + tbl[i].j;
      chk($sformatf("%s_wj_j%0d", tag, tbl[i].j), cap_wj[idx], tbl[i].wj);
      if (tbl[i].chk_wjj)
        chk($sformatf("%s_wjj_j%0d", tag, tbl[i].j), cap_wjj[idx], tbl[i].wjj);
    end
  endtask

  function automatic int lst_count(input int base);
    int n = 0;
    for (int i = 0; i < 64; i++) if (cap_lst[base + i]) n++;
    return n;
  endfunction

  initial begin
    int base;
    int s0;

    for (int i = 0; i < 16; i++) abc_w[i] = 32'h0;
    abc_w[0]  = 32'h61626380;
    abc_w[15] = 32'h00000018;

    tbl[0]  = '{0,  32'h61626380, 32'h61626380, 1'b1};
    tbl[1]  = '{1,  32'h00000000, 32'h00000000, 1'b1};
    tbl[2]  = '{3,  32'h00000000, 32'h00000000, 1'b1};
    tbl[3]  = '{11, 32'h00000000, 32'h00000018, 1'b1};
    tbl[4]  = '{12, 32'h00000000, 32'h9092e200, 1'b1};
    tbl[5]  = '{13, 32'h00000000, 32'h00000000, 1'b1};
    tbl[6]  = '{14, 32'h00000000, 32'h000c0606, 1'b1};
    tbl[7]  = '{15, 32'h00000018, 32'h719c70f5, 1'b1};
    tbl[8]  = '{16, 32'h9092e200, 32'h9092e200, 1'b1};
    tbl[9]  = '{17, 32'h00000000, 32'h00000000, 1'b0};
    tbl[10] = '{18, 32'h000c0606, 32'h00000000, 1'b0};
    tbl[11] = '{19, 32'h719c70ed, 32'h00000000, 1'b0};

    rst_n = 1'b0;
    bus.pad_inpt_wrd_i = '0;
    bus.pad_inpt_vld_i = 1'b0;
    bus.pad_inpt_lst_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_rdy", 32'(bus.pad_inpt_rdy_o), 32'd1);
    chk("reset_vld", 32'(bus.expnd_otpt_vld_o), 32'd0);
    chk("reset_lst", 32'(bus.expnd_otpt_lst_o), 32'd0);
    chk("reset_wj", bus.expnd_otpt_wj_o, 32'd0);
    chk("reset_wjj", bus.expnd_otpt_wjj_o, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Plain "abc" block, no final flag
    base = cap_n; s0 = seg_n;
    send_words(0, 15, -1, 0);
    idle_input();
    wait_rounds(base + 64, 200);
    check_table(base, "abc");
    chk("abc_lst_count", 32'(lst_count(base)), 32'd0);
    chk("abc_segments", 32'(seg_n - s0), 32'd1);
    chk("abc_run_len", 32'(run_len), 32'd64);

    // Final flag on word 15: lst only at j=63
    base = cap_n;
    send_words(0, 15, 15, 0);
    idle_input();
    wait_rounds(base + 64, 200);
    chk("lst15_count", 32'(lst_count(base)), 32'd1);
    chk("lst15_j63", 32'(cap_lst[base + 63]), 32'd1);

    // Flag on word 3 only is ignored
    base = cap_n;
    send_words(0, 15, 3, 0);
    idle_input();
    wait_rounds(base + 64, 200);
    chk("lst3_count", 32'(lst_count(base)), 32'd0);

    // Random input gaps
    base = cap_n; s0 = seg_n;
    send_words(0, 15, -1, 3);
    idle_input();
    wait_rounds(base + 64, 300);
    check_table(base, "gap");
    chk("gap_segments", 32'(seg_n - s0), 32'd1);
    chk("gap_run_len", 32'(run_len), 32'd64);

    // Two blocks back to back with vld held high
    base = cap_n; s0 = seg_n;
    send_words(0, 15, -1, 0);
    send_words(0, 15, 15, 0);
    idle_input();
    wait_rounds(base + 128, 400);
    check_table(base + 64, "b2b");
    chk("b2b_lst_j127", 32'(cap_lst[base + 127]), 32'd1);
`ifdef SM3_EXPND_PREFETCH_EN
    chk("b2b_segments", 32'(seg_n - s0), 32'd1);
    chk("b2b_run_len", 32'(run_len), 32'd128);
`else
    chk("b2b_segments", 32'(seg_n - s0), 32'd2);
    chk("b2b_gap", 32'(last_gap), 32'd16);
    chk("b2b_run_len", 32'(run_len), 32'd64);
`endif

    // Reset asserted while round j=30 is on the bus
    base = cap_n;
    send_words(0, 15, 15, 0);
    idle_input();
    wait_rounds(base + 31, 200);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_vld", 32'(bus.expnd_otpt_vld_o), 32'd0);
    chk("rst_mid_wj", bus.expnd_otpt_wj_o, 32'd0);
    chk("rst_mid_rdy", 32'(bus.pad_inpt_rdy_o), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_rel_rdy", 32'(bus.pad_inpt_rdy_o), 32'd1);
    chk("rst_rel_vld", 32'(bus.expnd_otpt_vld_o), 32'd0);
    @(posedge clk); #1;
    base = cap_n;
    send_words(0, 15, -1, 0);
    idle_input();
    wait_rounds(base + 64, 200);
    check_table(base, "post_rst");
    chk("post_rst_lst_count", 32'(lst_count(base)), 32'd0);

`ifdef SM3_EXPND_PREFETCH_EN
    // Only 7 words of the next block arrive during expansion
    base = cap_n;
    send_words(0, 15, -1, 0);
    send_words(0, 6, -1, 0);
    idle_input();
    wait_rounds(base + 64, 200);
    repeat (5) @(negedge clk);
    #1;
    chk("pf7_rdy_in_load", 32'(bus.pad_inpt_rdy_o), 32'd1);
    send_words(7, 15, 15, 0);
    idle_input();
    wait_rounds(base + 128, 200);
    check_table(base + 64, "pf7");
    chk("pf7_lst_count", 32'(lst_count(base + 64)), 32'd1);
`else
    chk("rdy_during_expnd", 32'(rdy_bad), 32'd0);
`endif
    chk("idle_outputs_zero", 32'(idle_bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
